// File: rtl/masked_present_pkg.sv
// Shared types and constants for the serialised masked PRESENT S-box layer.
// The S-box table is consumed by bench models; the datapath never unmasks.
package masked_present_pkg;

    localparam int          NSHARES      = 3;
    localparam int          RAND_W       = 12;
    // Right-shift Galois mask for x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] SEED_DEFAULT = 32'hACE1_2468;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // Entry i lives at bits [4i+3:4i]
    localparam logic [63:0] PRESENT_SBOX = 64'h2174_8FE3_DA09_B65C;

    function automatic logic [3:0] present_sbox(input logic [3:0] x);
        logic [63:0] t;
        t = PRESENT_SBOX;
        return t[x*4 +: 4];
    endfunction

endpackage

// File: rtl/masked_sbox_layer_seq_lfsr.sv
// Refresh-randomness source: 32-bit Galois LFSR advanced 12 steps per enable.
// Exposes the low 12 bits of the state it is about to enter.
module refresh_lfsr12
    import masked_present_pkg::*;
#(
    parameter logic [31:0] SEED = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [31:0]       seed_i,
    output logic [RAND_W-1:0] rnd_o
);

    localparam logic [31:0] SEED_SAFE = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] state_q;
    logic [31:0] state_d;
    logic [31:0] stepped;

    always_comb begin
        stepped = state_q;
        for (int i = 0; i < RAND_W; i++) begin
            stepped = stepped[0] ? ((stepped >> 1) ^ LFSR_POLY)
                                 : (stepped >> 1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
        end else if (en_i) begin
            state_d = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_SAFE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rnd_o = stepped[RAND_W-1:0];

endmodule

// File: rtl/masked_sbox_layer_seq.sv
// Streams a 3-share masked state nibble-by-nibble through an external
// pipelined masked S-box stage and reassembles the substituted shares.
module masked_sbox_layer_seq
    import masked_present_pkg::*;
#(
    parameter int          NIBBLES = 16,
    parameter int          SB_LAT  = 1,
    parameter logic [31:0] SEED    = SEED_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] st1,
    input  logic [4*NIBBLES-1:0] st2,
    input  logic [4*NIBBLES-1:0] st3,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] res1,
    output logic [4*NIBBLES-1:0] res2,
    output logic [4*NIBBLES-1:0] res3,
    output logic [3:0]           sb_in1,
    output logic [3:0]           sb_in2,
    output logic [3:0]           sb_in3,
    output logic [RAND_W-1:0]    sb_r,
    input  logic [3:0]           sb_out1,
    input  logic [3:0]           sb_out2,
    input  logic [3:0]           sb_out3
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + SB_LAT + 1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(NIBBLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(SB_LAT - 1);

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      sh1_q, sh2_q, sh3_q;
    logic [W-1:0]      sh1_d, sh2_d, sh3_d;
    logic [W-1:0]      res1_q, res2_q, res3_q;
    logic [W-1:0]      res1_d, res2_d, res3_d;
    logic [3:0]        in1_q, in2_q, in3_q;
    logic [3:0]        in1_d, in2_d, in3_d;
    logic [RAND_W-1:0] r_q, r_d;
    logic              feed_q, feed_d;
    logic [SB_LAT-1:0] vd_q, vd_d;
    logic              lfsr_en;
    logic              lfsr_load;
    logic [RAND_W-1:0] lfsr_rnd;

    refresh_lfsr12 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (lfsr_en),
        .load_i (lfsr_load),
        .seed_i (seed),
        .rnd_o  (lfsr_rnd)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        sh3_d     = sh3_q;
        in1_d     = 4'h0;
        in2_d     = 4'h0;
        in3_d     = 4'h0;
        r_d       = '0;
        feed_d    = 1'b0;
        lfsr_en   = 1'b0;
        lfsr_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    in1_d   = st1[3:0];
                    in2_d   = st2[3:0];
                    in3_d   = st3[3:0];
                    sh1_d   = st1 >> 4;
                    sh2_d   = st2 >> 4;
                    sh3_d   = st3 >> 4;
                    r_d     = lfsr_rnd;
                    lfsr_en = 1'b1;
                    feed_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_FEED;
                end else if (seed_load) begin
                    lfsr_load = 1'b1;
                end
            end
            ST_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    in1_d   = sh1_q[3:0];
                    in2_d   = sh2_q[3:0];
                    in3_d   = sh3_q[3:0];
                    sh1_d   = sh1_q >> 4;
                    sh2_d   = sh2_q >> 4;
                    sh3_d   = sh3_q >> 4;
                    r_d     = lfsr_rnd;
                    lfsr_en = 1'b1;
                    feed_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid tag trails each issued nibble by the stage latency
    always_comb begin
        vd_d   = (vd_q << 1) | SB_LAT'(feed_q);
        res1_d = res1_q;
        res2_d = res2_q;
        res3_d = res3_q;
        if (vd_q[SB_LAT-1]) begin
            res1_d = (res1_q >> 4) | (W'(sb_out1) << (W - 4));
            res2_d = (res2_q >> 4) | (W'(sb_out2) << (W - 4));
            res3_d = (res3_q >> 4) | (W'(sb_out3) << (W - 4));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            sh3_q   <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
            res3_q  <= '0;
            in1_q   <= 4'h0;
            in2_q   <= 4'h0;
            in3_q   <= 4'h0;
            r_q     <= '0;
            feed_q  <= 1'b0;
            vd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            sh3_q   <= sh3_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            res3_q  <= res3_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            in3_q   <= in3_d;
            r_q     <= r_d;
            feed_q  <= feed_d;
            vd_q    <= vd_d;
        end
    end

    assign busy   = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign done   = (state_q == ST_DONE);
    assign res1   = res1_q;
    assign res2   = res2_q;
    assign res3   = res3_q;
    assign sb_in1 = in1_q;
    assign sb_in2 = in2_q;
    assign sb_in3 = in3_q;
    assign sb_r   = r_q;

endmodule

// File: tb/tb_masked_sbox_layer_seq.sv
// Scoreboard bench: two sequencers (S-box latency 1 and 3) share one stimulus
// stream; per-instance monitors pop expected results and refresh words.
`timescale 1ns/1ps
module tb_masked_sbox_layer_seq;
    import masked_present_pkg::*;

    localparam int          NIB     = 16;
    localparam logic [31:0] TB_SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [31:0] seed;
    logic [63:0] st1, st2, st3;

    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    bit          op_on    = 1'b0;
    int          base     = 0;
    logic [31:0] lfsr_m;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [31:0] lstep12(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 12; i++)
            t = t[0] ? ((t >> 1) ^ 32'h8020_0003) : (t >> 1);
        return t;
    endfunction

    // Unmask, substitute, remask with two nibbles of the refresh word
    function automatic logic [11:0] sb_model(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] c,
                                             input logic [11:0] r);
        logic [3:0] y;
        y = present_sbox(a ^ b ^ c);
        return {y ^ r[3:0] ^ r[7:4], r[7:4], r[3:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        busy, done;
        logic [63:0] res1, res2, res3;
        logic [3:0]  sb_in1, sb_in2, sb_in3;
        logic [3:0]  sb_out1, sb_out2, sb_out3;
        logic [11:0] sb_r;
        logic [11:0] pipe [LAT];
        logic [63:0] exp_q [$];
        logic [11:0] r_q [$];

        masked_sbox_layer_seq #(
            .NIBBLES (NIB),
            .SB_LAT  (LAT),
            .SEED    (TB_SEED)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .st1       (st1),
            .st2       (st2),
            .st3       (st3),
            .seed_load (seed_load),
            .seed      (seed),
            .busy      (busy),
            .done      (done),
            .res1      (res1),
            .res2      (res2),
            .res3      (res3),
            .sb_in1    (sb_in1),
            .sb_in2    (sb_in2),
            .sb_in3    (sb_in3),
            .sb_r      (sb_r),
            .sb_out1   (sb_out1),
            .sb_out2   (sb_out2),
            .sb_out3   (sb_out3)
        );

        always @(posedge clk) begin
            pipe[0] <= sb_model(sb_in1, sb_in2, sb_in3, sb_r);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        assign {sb_out3, sb_out2, sb_out1} = pipe[LAT-1];

        always @(negedge clk) begin : mon
            int rel;
            bit eb, ed;
            rel = cyc - base;
            if (mon_en) begin
                if (op_on && rel >= 1 && rel <= NIB) begin
                    if (r_q.size() == 0)
                        fail($sformatf("sb_r_queue lat%0d", LAT));
                    else
                        chk($sformatf("sb_r[%0d] lat%0d", rel, LAT),
                            64'(sb_r), 64'(r_q.pop_front()));
                end else begin
                    chk($sformatf("idle_drive lat%0d", LAT),
                        64'({sb_in3, sb_in2, sb_in1, sb_r}), 64'h0);
                end
                eb = op_on && rel >= 1 && rel <= NIB + LAT;
                ed = op_on && rel == NIB + LAT + 1;
                chk($sformatf("busy rel%0d lat%0d", rel, LAT),
                    64'(busy), 64'(eb));
                chk($sformatf("done rel%0d lat%0d", rel, LAT),
                    64'(done), 64'(ed));
                if (done) begin
                    if (exp_q.size() == 0)
                        fail($sformatf("done_extra lat%0d", LAT));
                    else
                        chk($sformatf("res_xor lat%0d", LAT),
                            res1 ^ res2 ^ res3, exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_op(input logic [63:0] p, input logic [63:0] exp,
                          input bit collide, input bit with_seed,
                          input int rst_at, input bit c01);
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        @(posedge clk); #1;
        st1   = a;
        st2   = b;
        st3   = p ^ a ^ b;
        start = 1'b1;
        if (with_seed) begin
            seed_load = 1'b1;
            seed      = 32'hDEAD_BEEF;
        end
        base  = cyc;
        op_on = 1'b1;
        g_dut[0].exp_q.push_back(exp);
        g_dut[1].exp_q.push_back(exp);
        for (int k = 0; k < NIB; k++) begin
            lfsr_m = lstep12(lfsr_m);
            g_dut[0].r_q.push_back(lfsr_m[11:0]);
            g_dut[1].r_q.push_back(lfsr_m[11:0]);
        end
        for (int rel = 1; rel <= NIB + 6; rel++) begin
            @(posedge clk); #1;
            start     = collide && (rel == 5 || rel == 10);
            seed_load = 1'b0;
            st1       = {$urandom, $urandom};
            st2       = {$urandom, $urandom};
            st3       = {$urandom, $urandom};
            if (c01 && rel == 1)
                chk("sb_r_first_seed0", 64'(g_dut[0].sb_r), 64'hC01);
            if (rst_at != 0 && rel == rst_at) rst = 1'b1;
            if (rst_at != 0 && rel == rst_at + 1) begin
                rst   = 1'b0;
                op_on = 1'b0;
                g_dut[0].exp_q.delete();
                g_dut[1].exp_q.delete();
                g_dut[0].r_q.delete();
                g_dut[1].r_q.delete();
                lfsr_m = TB_SEED;
                chk("abort_res0", g_dut[0].res1 | g_dut[0].res2 | g_dut[0].res3, 64'h0);
                chk("abort_res1", g_dut[1].res1 | g_dut[1].res2 | g_dut[1].res3, 64'h0);
                chk("abort_busy", 64'({g_dut[1].busy, g_dut[0].busy}), 64'h0);
                repeat (NIB) @(posedge clk);
                #1;
                return;
            end
        end
        op_on = 1'b0;
        chk("done_seen0", 64'(g_dut[0].exp_q.size()), 64'h0);
        chk("done_seen1", 64'(g_dut[1].exp_q.size()), 64'h0);
        g_dut[0].exp_q.delete();
        g_dut[1].exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("res_hold0", g_dut[0].res1 ^ g_dut[0].res2 ^ g_dut[0].res3, exp);
        chk("res_hold1", g_dut[1].res1 ^ g_dut[1].res2 ^ g_dut[1].res3, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        seed_load = 1'b0;
        seed      = 32'h0;
        st1       = '0;
        st2       = '0;
        st3       = '0;
        lfsr_m    = TB_SEED;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("reset_res0", g_dut[0].res1 | g_dut[0].res2 | g_dut[0].res3, 64'h0);
        chk("reset_res1", g_dut[1].res1 | g_dut[1].res2 | g_dut[1].res3, 64'h0);

        run_op(64'h0123_4567_89AB_CDEF, 64'hC56B_90AD_3EF8_4712, 0, 0, 0, 0);

        @(posedge clk); #1;
        seed_load = 1'b1;
        seed      = 32'h0;
        lfsr_m    = 32'h1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        repeat (5) @(posedge clk);

        run_op(64'hFEDC_BA98_7654_3210, 64'h2174_8FE3_DA09_B65C, 1, 0, 0, 1);
        repeat (4) @(posedge clk);
        run_op(64'h0, 64'hCCCC_CCCC_CCCC_CCCC, 0, 1, 0, 0);
        run_op(64'h0123_4567_89AB_CDEF, 64'hC56B_90AD_3EF8_4712, 0, 0, 8, 0);
        run_op(64'h0123_4567_89AB_CDEF, 64'hC56B_90AD_3EF8_4712, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
